// File: rtl/regfile_scoreboard.sv
// Multi-read-port integer register file with a per-register pending-write scoreboard.
// Decode reserves a destination; writeback fills it and clears the reservation.
module regfile_scoreboard #(
  parameter int DEPTH    = 32,
  parameter int BITS     = 64,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREAD*AW-1:0]   raddr,
  output logic [NREAD*BITS-1:0] rdata,
  output logic [NREAD-1:0]      rbusy,
  input  logic                  wen,
  input  logic [AW-1:0]         waddr,
  input  logic [BITS-1:0]       wdata,
  input  logic                  rsv_en,
  input  logic [AW-1:0]         rsv_addr,
  output logic                  rsv_ok,
  output logic [DEPTH-1:0]      busy_vec
);

  logic [BITS-1:0]  regs [DEPTH];
  logic [DEPTH-1:0] busy;

  // Addresses that never touch storage: beyond DEPTH, or the hardwired zero register.
  function automatic logic masked(input logic [AW-1:0] a);
    return (32'(a) >= DEPTH) || ((ZERO_REG != 0) && (a == '0));
  endfunction

  logic wr_hit;
  logic rsv_take;

  assign wr_hit   = wen && !masked(waddr);
  assign rsv_ok   = !rsv_en || masked(rsv_addr) || !busy[rsv_addr] ||
                    (wen && (waddr == rsv_addr));
  assign rsv_take = rsv_en && rsv_ok && !masked(rsv_addr);
  assign busy_vec = busy;

  // Reservation is applied after the write so a same-register write+reserve leaves busy set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (wr_hit) begin
        regs[waddr] <= wdata;
        busy[waddr] <= 1'b0;
      end
      if (rsv_take) busy[rsv_addr] <= 1'b1;
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0]   a;
    logic [BITS-1:0] d;
    logic            b;

    assign a = raddr[k*AW +: AW];

    always_comb begin
      d = '0;
      b = 1'b0;
      if (!masked(a)) begin
        // Bypass is held off during reset so reads stay 0 while rst is high.
        if ((BYPASS != 0) && wr_hit && !rst && (waddr == a)) begin
          d = wdata;
        end else begin
          d = regs[a];
          b = busy[a];
        end
      end
    end

    assign rdata[k*BITS +: BITS] = d;
    assign rbusy[k]              = b;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: default 32x64 file with bypass and a
// 24-entry, 4-port, no-bypass variant.
module tb_regfile_scoreboard;
  localparam int AW = 5;
  localparam int B  = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2*AW-1:0] raddr;
  logic [2*B-1:0]  rdata;
  logic [1:0]      rbusy;
  logic            wen, rsv_en, rsv_ok;
  logic [AW-1:0]   waddr, rsv_addr;
  logic [B-1:0]    wdata;
  logic [31:0]     busy_vec;

  logic [4*AW-1:0] raddr6;
  logic [4*B-1:0]  rdata6;
  logic [3:0]      rbusy6;
  logic            wen6, rsv_en6, rsv_ok6;
  logic [AW-1:0]   waddr6, rsv_addr6;
  logic [B-1:0]    wdata6;
  logic [23:0]     busy_vec6;

  regfile_scoreboard #(.DEPTH(32), .BITS(64), .NREAD(2), .ZERO_REG(1), .BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .wen(wen), .waddr(waddr), .wdata(wdata), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rsv_ok(rsv_ok), .busy_vec(busy_vec)
  );

  regfile_scoreboard #(.DEPTH(24), .BITS(64), .NREAD(4), .ZERO_REG(1), .BYPASS(0)) u_dut6 (
    .clk(clk), .rst(rst), .raddr(raddr6), .rdata(rdata6), .rbusy(rbusy6),
    .wen(wen6), .waddr(waddr6), .wdata(wdata6), .rsv_en(rsv_en6), .rsv_addr(rsv_addr6),
    .rsv_ok(rsv_ok6), .busy_vec(busy_vec6)
  );

  typedef struct packed {
    logic        d6;
    logic [1:0]  kind;   // 0 rdata, 1 rbusy, 2 busy_vec, 3 rsv_ok
    logic [2:0]  port;
    logic [63:0] exp;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input bit d6, input int kind, input int port,
                         input logic [63:0] v);
    exp_t e;
    e.d6   = d6;
    e.kind = 2'(kind);
    e.port = 3'(port);
    e.exp  = v;
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic drain();
    exp_t        e;
    string       t;
    logic [63:0] obs;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      case (e.kind)
        2'd0:    obs = e.d6 ? rdata6[int'(e.port)*B +: B] : rdata[int'(e.port)*B +: B];
        2'd1:    obs = 64'(e.d6 ? rbusy6[int'(e.port)] : rbusy[int'(e.port)]);
        2'd2:    obs = e.d6 ? 64'(busy_vec6) : 64'(busy_vec);
        default: obs = 64'(e.d6 ? rsv_ok6 : rsv_ok);
      endcase
      chk(t, obs, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ra(input int port, input logic [AW-1:0] a);
    raddr[port*AW +: AW] = a;
  endtask

  task automatic set_ra6(input int port, input logic [AW-1:0] a);
    raddr6[port*AW +: AW] = a;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    int a;
    logic [63:0] ev;
    rst = 1'b1;
    raddr = '0; wen = 0; waddr = '0; wdata = '0; rsv_en = 0; rsv_addr = '0;
    raddr6 = '0; wen6 = 0; waddr6 = '0; wdata6 = '0; rsv_en6 = 0; rsv_addr6 = '0;
    #2;
    sb_push("rst rdata0", 0, 0, 0, 64'h0);
    sb_push("rst rbusy0", 0, 1, 0, 64'h0);
    sb_push("rst busy_vec", 0, 2, 0, 64'h0);
    sb_push("rst rsv_ok", 0, 3, 0, 64'h1);
    drain();
    @(posedge clk); @(posedge clk); #3 rst = 1'b0;

    // async reset mid-run
    tick(); wen = 1; waddr = 1; wdata = 64'hA5; rsv_en = 1; rsv_addr = 4;
    tick(); wen = 0; rsv_addr = 5;
    tick(); rsv_addr = 6;
    tick(); rsv_addr = 7;
    tick(); rsv_en = 0; set_ra(0, 1); set_ra(1, 4);
    #1;
    sb_push("pre-rst rdata0", 0, 0, 0, 64'hA5);
    sb_push("pre-rst busy_vec", 0, 2, 0, 64'hF0);
    sb_push("pre-rst rbusy1", 0, 1, 1, 64'h1);
    drain();
    #1 rst = 1'b1;
    #1;
    sb_push("async rdata0", 0, 0, 0, 64'h0);
    sb_push("async rbusy1", 0, 1, 1, 64'h0);
    sb_push("async busy_vec", 0, 2, 0, 64'h0);
    drain();
    #1 rst = 1'b0;
    #1;
    sb_push("post-rst rdata0", 0, 0, 0, 64'h0);
    sb_push("post-rst busy_vec", 0, 2, 0, 64'h0);
    drain();
    tick(); #1;
    sb_push("post-rst edge rdata0", 0, 0, 0, 64'h0);
    sb_push("post-rst edge busy_vec", 0, 2, 0, 64'h0);
    drain();

    // bypass
    tick(); wen = 1; waddr = 5; wdata = 64'h1234; set_ra(0, 5); set_ra(1, 0);
    #1;
    sb_push("bypass rdata0", 0, 0, 0, 64'h1234);
    sb_push("bypass rbusy0", 0, 1, 0, 64'h0);
    drain();
    tick(); wen = 0; set_ra(1, 5);
    #1;
    sb_push("stored rdata1", 0, 0, 1, 64'h1234);
    drain();

    // zero register
    tick(); wen = 1; waddr = 0; wdata = 64'hFFFF; set_ra(0, 0);
    #1;
    sb_push("zero write rdata0", 0, 0, 0, 64'h0);
    drain();
    tick(); wen = 0; rsv_en = 1; rsv_addr = 0;
    #1;
    sb_push("zero rsv_ok", 0, 3, 0, 64'h1);
    sb_push("zero rdata0", 0, 0, 0, 64'h0);
    drain();
    tick(); rsv_en = 0;
    #1;
    sb_push("zero busy_vec", 0, 2, 0, 64'h0);
    sb_push("zero rbusy0", 0, 1, 0, 64'h0);
    sb_push("zero rdata0 later", 0, 0, 0, 64'h0);
    drain();

    // reserve, WAW reject, writeback
    tick(); rsv_en = 1; rsv_addr = 7;
    #1;
    sb_push("rsv7 rsv_ok", 0, 3, 0, 64'h1);
    drain();
    tick(); rsv_en = 0; set_ra(1, 7);
    #1;
    sb_push("rsv7 rbusy1", 0, 1, 1, 64'h1);
    sb_push("rsv7 busy_vec", 0, 2, 0, 64'h80);
    drain();
    tick(); rsv_en = 1; rsv_addr = 7;
    #1;
    sb_push("waw rsv_ok", 0, 3, 0, 64'h0);
    drain();
    tick(); rsv_en = 0; wen = 1; waddr = 7; wdata = 64'hBEEF;
    #1;
    sb_push("waw kept busy_vec", 0, 2, 0, 64'h80);
    sb_push("wb7 bypass rbusy1", 0, 1, 1, 64'h0);
    sb_push("wb7 bypass rdata1", 0, 0, 1, 64'hBEEF);
    drain();
    tick(); wen = 0;
    #1;
    sb_push("wb7 rbusy1", 0, 1, 1, 64'h0);
    sb_push("wb7 rdata1", 0, 0, 1, 64'hBEEF);
    sb_push("wb7 busy_vec", 0, 2, 0, 64'h0);
    drain();

    // write and reserve the same register in one cycle
    tick(); rsv_en = 1; rsv_addr = 9;
    tick(); wen = 1; waddr = 9; wdata = 64'h55;
    #1;
    sb_push("wr+rsv9 rsv_ok", 0, 3, 0, 64'h1);
    drain();
    tick(); wen = 0; rsv_en = 0; set_ra(0, 9);
    #1;
    sb_push("wr+rsv9 rdata0", 0, 0, 0, 64'h55);
    sb_push("wr+rsv9 rbusy0", 0, 1, 0, 64'h1);
    sb_push("wr+rsv9 busy_vec", 0, 2, 0, 64'h200);
    drain();

    // write and reserve different registers in one cycle
    tick(); wen = 1; waddr = 3; wdata = 64'h77; rsv_en = 1; rsv_addr = 10; set_ra(1, 3);
    #1;
    sb_push("wr3 rsv10 rdata1", 0, 0, 1, 64'h77);
    sb_push("wr3 rsv10 rsv_ok", 0, 3, 0, 64'h1);
    drain();
    tick(); wen = 0; rsv_en = 0;
    #1;
    sb_push("wr3 rsv10 rdata1 later", 0, 0, 1, 64'h77);
    sb_push("wr3 rsv10 busy_vec", 0, 2, 0, 64'h600);
    sb_push("wr3 rsv10 rbusy0", 0, 1, 0, 64'h1);
    drain();

    // 24-entry, 4-port, no-bypass variant
    tick(); rsv_en6 = 1; rsv_addr6 = 2;
    tick(); rsv_en6 = 0;
    for (int i = 1; i < 24; i++) begin
      wen6 = 1; waddr6 = AW'(i); wdata6 = 64'(i * 3); set_ra6(0, AW'(i));
      #1;
      if (i == 1) sb_push("nobyp rdata a1", 1, 0, 0, 64'h0);
      if (i == 2) begin
        sb_push("nobyp rdata a2", 1, 0, 0, 64'h0);
        sb_push("nobyp rbusy a2", 1, 1, 0, 64'h1);
      end
      drain();
      tick();
    end
    wen6 = 0;
    for (int base = 1; base < 24; base += 4) begin
      for (int p = 0; p < 4; p++) set_ra6(p, AW'(base + p));
      #1;
      for (int p = 0; p < 4; p++) begin
        a  = base + p;
        ev = (a < 24) ? 64'(a * 3) : 64'h0;
        sb_push($sformatf("d24 rdata p%0d a%0d", p, a), 1, 0, p, ev);
        sb_push($sformatf("d24 rbusy p%0d a%0d", p, a), 1, 1, p, 64'h0);
      end
      drain();
    end
    set_ra6(0, 30); set_ra6(1, 24); set_ra6(2, 14); set_ra6(3, 23);
    rsv_en6 = 1; rsv_addr6 = 30; wen6 = 1; waddr6 = 30; wdata6 = '1;
    #1;
    sb_push("oor rdata a30", 1, 0, 0, 64'h0);
    sb_push("oor rbusy a30", 1, 1, 0, 64'h0);
    sb_push("oor rsv_ok", 1, 3, 0, 64'h1);
    drain();
    tick(); rsv_en6 = 0; wen6 = 0;
    #1;
    sb_push("oor busy_vec", 1, 2, 0, 64'h0);
    sb_push("oor rdata a30 after", 1, 0, 0, 64'h0);
    sb_push("oor rdata a24 after", 1, 0, 1, 64'h0);
    sb_push("oor rdata a14 intact", 1, 0, 2, 64'd42);
    sb_push("oor rdata a23 intact", 1, 0, 3, 64'd69);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
